// File: rtl/router_pkg.sv
// Shared constants and types for the 1x3 router datapath.
// The header flag sits above the data byte in every FIFO entry.
package router_pkg;

    localparam int DATA_W       = 8;
    localparam int FIFO_DEPTH   = 16;
    localparam int FIFO_ADDR_W  = 4;
    localparam int HDR_FLAG_BIT = DATA_W;
    localparam int LEN_MSB      = 7;
    localparam int LEN_LSB      = 2;
    localparam int LEN_W        = LEN_MSB - LEN_LSB + 1;
    localparam int PKT_CNT_W    = LEN_W + 1;

    typedef struct packed {
        logic              hdr;
        logic [DATA_W-1:0] data;
    } fifo_entry_t;

    // A header announces its payload length; the parity byte adds one more.
    function automatic logic [PKT_CNT_W-1:0] pktLenToCount(input logic [LEN_W-1:0] len);
        return {1'b0, len} + PKT_CNT_W'(1);
    endfunction

endpackage

// File: rtl/router_fifo_if.sv
// Write/read handshake bundle between the router core, a destination FIFO
// and that destination's read port.
interface router_fifo_if;
    import router_pkg::*;

    logic              write_enb;
    logic              read_enb;
    logic              lfd_state;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              full;
    logic              empty;

    modport master (
        output write_enb, read_enb, lfd_state, data_in,
        input  data_out, full, empty
    );

    modport slave (
        input  write_enb, read_enb, lfd_state, data_in,
        output data_out, full, empty
    );

endinterface

// File: rtl/router_fifo_pkt_cnt.sv
// Tracks how many bytes of the packet being read are still to come, so the
// FIFO output can fall back to idle once a packet has fully drained.
module router_fifo_pkt_cnt
    import router_pkg::*;
(
    input  logic             clock,
    input  logic             resetn,
    input  logic             soft_reset,
    input  logic             rdAccept_i,
    input  logic             rdHdr_i,
    input  logic [LEN_W-1:0] rdLen_i,
    output logic             cntZero_o
);

    logic [PKT_CNT_W-1:0] pktCnt_q;
    logic [PKT_CNT_W-1:0] pktCnt_d;

    // A header always reloads, even mid-packet, so packets can abut.
    always_comb begin
        pktCnt_d = pktCnt_q;
        if (soft_reset) begin
            pktCnt_d = '0;
        end else if (rdAccept_i) begin
            if (rdHdr_i) begin
                pktCnt_d = pktLenToCount(rdLen_i);
            end else if (pktCnt_q != '0) begin
                pktCnt_d = pktCnt_q - PKT_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            pktCnt_q <= '0;
        end else begin
            pktCnt_q <= pktCnt_d;
        end
    end

    assign cntZero_o = (pktCnt_q == '0);

endmodule

// File: rtl/router_fifo.sv
// Per-destination 16-entry byte buffer of the 1x3 router; header bytes are
// tagged so the reader side can follow packet boundaries.
module router_fifo
    import router_pkg::*;
(
    input  logic          clock,
    input  logic          resetn,
    input  logic          soft_reset,
    router_fifo_if.slave  bus
);

    logic [FIFO_ADDR_W:0] wrPtr_q;
    logic [FIFO_ADDR_W:0] wrPtr_d;
    logic [FIFO_ADDR_W:0] rdPtr_q;
    logic [FIFO_ADDR_W:0] rdPtr_d;
    logic [DATA_W-1:0]    dataOut_q;
    logic [DATA_W-1:0]    dataOut_d;
    fifo_entry_t          mem_q [FIFO_DEPTH];

    logic        fullFlag;
    logic        emptyFlag;
    logic        wrAccept;
    logic        rdAccept;
    logic        cntZero;
    fifo_entry_t rdEntry;
    fifo_entry_t wrEntry;

    // The extra pointer bit separates a full FIFO from an empty one.
    assign emptyFlag = (wrPtr_q == rdPtr_q);
    assign fullFlag  = (wrPtr_q[FIFO_ADDR_W-1:0] == rdPtr_q[FIFO_ADDR_W-1:0]) &&
                       (wrPtr_q[FIFO_ADDR_W] != rdPtr_q[FIFO_ADDR_W]);

    assign wrAccept = bus.write_enb && !fullFlag && !soft_reset;
    assign rdAccept = bus.read_enb && !emptyFlag && !soft_reset;

    assign rdEntry      = mem_q[rdPtr_q[FIFO_ADDR_W-1:0]];
    assign wrEntry.hdr  = bus.lfd_state;
    assign wrEntry.data = bus.data_in;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (soft_reset) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
        end else begin
            if (wrAccept) begin
                wrPtr_d = wrPtr_q + (FIFO_ADDR_W+1)'(1);
            end
            if (rdAccept) begin
                rdPtr_d = rdPtr_q + (FIFO_ADDR_W+1)'(1);
            end
        end
    end

    // Between packets the output idles at zero instead of holding the parity byte.
    always_comb begin
        dataOut_d = dataOut_q;
        if (soft_reset) begin
            dataOut_d = '0;
        end else if (rdAccept) begin
            dataOut_d = rdEntry.data;
        end else if (cntZero) begin
            dataOut_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            dataOut_q <= '0;
        end else begin
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            dataOut_q <= dataOut_d;
        end
    end

    always_ff @(posedge clock) begin
        if (resetn && wrAccept) begin
            mem_q[wrPtr_q[FIFO_ADDR_W-1:0]] <= wrEntry;
        end
    end

    router_fifo_pkt_cnt u_pktCnt (
        .clock      (clock),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .rdAccept_i (rdAccept),
        .rdHdr_i    (rdEntry.hdr),
        .rdLen_i    (rdEntry.data[LEN_MSB:LEN_LSB]),
        .cntZero_o  (cntZero)
    );

    assign bus.data_out = dataOut_q;
    assign bus.full     = fullFlag;
    assign bus.empty    = emptyFlag;

endmodule

// File: tb/tb_router_fifo.sv
// Self-checking bench for router_fifo: directed packet scenarios followed by
// random traffic, all compared against a queue-based packet model.
module tb_router_fifo;

    logic clock;
    logic resetn;
    logic soft_reset;

    router_fifo_if bus ();

    router_fifo dut (
        .clock      (clock),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .bus        (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checkCount = 0;
    int failCount  = 0;

    logic [8:0] modelQ[$];
    int         modelRemain;
    logic [7:0] modelOut;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, check at the negedge.
    task automatic applyStimulus(input logic rn, input logic sr, input logic we,
                                 input logic re, input logic lfd, input logic [7:0] din);
        logic       canRead;
        logic       canWrite;
        logic [8:0] entry;
        resetn        = rn;
        soft_reset    = sr;
        bus.write_enb = we;
        bus.read_enb  = re;
        bus.lfd_state = lfd;
        bus.data_in   = din;
        @(posedge clock);
        if (!rn || sr) begin
            modelQ.delete();
            modelRemain = 0;
            modelOut    = 8'h00;
        end else begin
            canRead  = re && (modelQ.size() != 0);
            canWrite = we && (modelQ.size() != 16);
            if (canRead) begin
                entry    = modelQ.pop_front();
                modelOut = entry[7:0];
                if (entry[8]) modelRemain = int'(entry[7:2]) + 1;
                else if (modelRemain > 0) modelRemain--;
            end else if (modelRemain == 0) begin
                modelOut = 8'h00;
            end
            if (canWrite) modelQ.push_back({lfd, din});
        end
        @(negedge clock);
        checkOutput("data_out", 32'(bus.data_out), 32'(modelOut));
        checkOutput("full", 32'(bus.full), 32'(modelQ.size() == 16));
        checkOutput("empty", 32'(bus.empty), 32'(modelQ.size() == 0));
    endtask

    task automatic writeByte(input logic lfd, input logic [7:0] din);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, lfd, din);
    endtask

    task automatic readByte();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        logic [7:0] planBytes [5];
        modelRemain   = 0;
        modelOut      = 8'h00;
        resetn        = 1'b0;
        soft_reset    = 1'b0;
        bus.write_enb = 1'b0;
        bus.read_enb  = 1'b0;
        bus.lfd_state = 1'b0;
        bus.data_in   = 8'h00;

        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h55);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 8'h00);
        checkOutput("reset_data_out", 32'(bus.data_out), 32'h0);
        checkOutput("reset_empty", 32'(bus.empty), 32'h1);

        planBytes[0] = 8'h0D;
        planBytes[1] = 8'hA1;
        planBytes[2] = 8'hA2;
        planBytes[3] = 8'hA3;
        planBytes[4] = 8'h5F;
        for (int i = 0; i < 5; i++) writeByte(i == 0, planBytes[i]);
        for (int i = 0; i < 5; i++) begin
            readByte();
            checkOutput("pkt_byte", 32'(bus.data_out), 32'(planBytes[i]));
        end
        idleCycle();
        checkOutput("pkt_idle", 32'(bus.data_out), 32'h0);
        checkOutput("pkt_empty", 32'(bus.empty), 32'h1);

        for (int i = 0; i < 16; i++) writeByte(i == 0, (i == 0) ? 8'h38 : 8'(8'h10 + i));
        checkOutput("full_after_16", 32'(bus.full), 32'h1);
        writeByte(1'b0, 8'hEE);
        for (int i = 0; i < 16; i++) begin
            readByte();
            checkOutput("no_dropped_ee", 32'(bus.data_out == 8'hEE), 32'h0);
        end
        checkOutput("drain_empty", 32'(bus.empty), 32'h1);

        for (int i = 0; i < 12; i++) writeByte(i == 0, 8'(8'h40 + i));
        for (int i = 0; i < 8; i++) readByte();
        for (int i = 0; i < 10; i++) writeByte(1'b0, 8'(8'h80 + i));
        for (int i = 0; i < 14; i++) readByte();
        idleCycle();

        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h04);
        checkOutput("empty_rw_reject", 32'(bus.data_out), 32'h0);
        checkOutput("empty_rw_notempty", 32'(bus.empty), 32'h0);
        readByte();
        checkOutput("empty_rw_read", 32'(bus.data_out), 32'h04);
        readByte();

        writeByte(1'b1, 8'h0C);
        for (int i = 0; i < 4; i++) writeByte(1'b0, 8'(8'hC0 + i));
        readByte();
        readByte();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h99);
        checkOutput("soft_data_out", 32'(bus.data_out), 32'h0);
        checkOutput("soft_empty", 32'(bus.empty), 32'h1);
        writeByte(1'b1, 8'h00);
        writeByte(1'b0, 8'h33);
        readByte();
        checkOutput("len0_hdr", 32'(bus.data_out), 32'h00);
        readByte();
        checkOutput("len0_parity", 32'(bus.data_out), 32'h33);
        idleCycle();
        checkOutput("len0_idle", 32'(bus.data_out), 32'h00);

        writeByte(1'b1, 8'hFC);
        for (int i = 0; i < 7; i++) writeByte(1'b0, 8'(8'h60 + i));
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'(8'h70 + i));
        checkOutput("steady_full", 32'(bus.full), 32'h0);
        checkOutput("steady_empty", 32'(bus.empty), 32'h0);
        for (int i = 0; i < 9; i++) readByte();

        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 99) != 0), ($urandom_range(0, 39) == 0),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) == 0), 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
